// File: rtl/necpu_pkg.sv
// Shared definitions for NECPU bus peripherals: register offsets, CTRL bit
// positions and LED polarity.
package necpu_pkg;

  // Register offsets relative to the peripheral base address
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_DUTY_R = 3'd1;
  localparam logic [2:0] OFF_DUTY_G = 3'd2;
  localparam logic [2:0] OFF_DUTY_B = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;
  localparam logic [2:0] OFF_LAST   = OFF_PRESC;

  // Sticky period-wrap flag position in CTRL
  localparam int WRAP_BIT = 7;

  // LED pins are active-low, so a high level means dark
  localparam logic LED_OFF = 1'b1;

  // Channel enables as they sit in CTRL[2:0]: R is bit 2, B is bit 0
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_en_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: double-buffered duty register, compare against the
// shared period counter and a registered active-low LED drive.
module pwm_channel
  import necpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shadow_we,
  input  logic [7:0] shadow_din,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] cnt,
  output logic [7:0] shadow_q,
  output logic       led_n
);

  logic [7:0] active_duty;
  logic       on;

  // Lit while enabled and the counter is still below the active duty
  assign on = enable && (cnt < active_duty);

  // Shadow takes CPU writes; active only changes at a period boundary, and a
  // write landing on the boundary cycle is not seen until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= 8'h00;
      active_duty <= 8'h00;
    end else begin
      if (shadow_we) shadow_q <= shadow_din;
      if (load)      active_duty <= shadow_q;
    end
  end

  // Registered active-low pin drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_n <= LED_OFF;
    else      led_n <= ~on;
  end

endmodule

// File: rtl/rgb_pwm_periph.sv
// Memory-mapped RGB LED PWM controller for the NECPU bus: register decode,
// prescaler, shared period counter, sticky WRAP flag and read-data register.
module rgb_pwm_periph
  import necpu_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'd128,
  parameter int         PRESC_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       led_R,
  output logic       led_G,
  output logic       led_B
);

  logic [8:0]         offset9;
  logic [2:0]         off;
  logic               mapped;
  logic               wr_en;
  logic               rd_en;
  logic               we_ctrl;
  logic               we_presc;
  logic               rd_ctrl;
  rgb_en_t            ctrl_en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         cnt;
  logic               wrap;
  logic               tick;
  logic               boundary;
  logic [7:0]         rd_data;
  logic [7:0]         shadow_r;
  logic [7:0]         shadow_g;
  logic [7:0]         shadow_b;

  // A 9-bit subtraction makes addresses below the base wrap to large values,
  // so one compare covers both ends of the window
  assign offset9 = {1'b0, address} - {1'b0, BASE_ADDR};
  assign mapped  = (offset9 <= {6'd0, OFF_LAST});
  assign off     = offset9[2:0];

  // A write wins over a simultaneous read; the read is dropped entirely
  assign wr_en    = write && mapped;
  assign rd_en    = read && !write && mapped;
  assign we_ctrl  = wr_en && (off == OFF_CTRL);
  assign we_presc = wr_en && (off == OFF_PRESC);
  assign rd_ctrl  = rd_en && (off == OFF_CTRL);

  assign tick     = (presc_cnt == presc);
  assign boundary = tick && (cnt == 8'hFF);

  // CTRL enables and the prescaler divisor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en <= '0;
      presc   <= '0;
    end else begin
      if (we_ctrl)  ctrl_en <= rgb_en_t'(din[2:0]);
      if (we_presc) presc   <= PRESC_W'(din);
    end
  end

  // Prescaler counts 0..presc; rewriting the divisor restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          presc_cnt <= '0;
    else if (we_presc) presc_cnt <= '0;
    else if (tick)     presc_cnt <= '0;
    else               presc_cnt <= presc_cnt + 1'b1;
  end

  // Free-running 8-bit period counter, wrapping 255 -> 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= 8'h00;
    else if (tick) cnt <= cnt + 8'd1;
  end

  // Sticky WRAP: a boundary sets it and beats a coincident CTRL read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wrap <= 1'b0;
    else if (boundary) wrap <= 1'b1;
    else if (rd_ctrl)  wrap <= 1'b0;
  end

  // Read mux over the current (pre-update) register values
  always_comb begin
    rd_data = 8'h00;
    unique case (off)
      OFF_CTRL: begin
        rd_data[WRAP_BIT] = wrap;
        rd_data[2:0]      = ctrl_en;
      end
      OFF_DUTY_R: rd_data = shadow_r;
      OFF_DUTY_G: rd_data = shadow_g;
      OFF_DUTY_B: rd_data = shadow_b;
      OFF_PRESC:  rd_data = 8'(presc);
      default:    rd_data = 8'h00;
    endcase
  end

  // Read data is valid only in the cycle after an accepted read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       dout <= 8'h00;
    else if (rd_en) dout <= rd_data;
    else            dout <= 8'h00;
  end

  pwm_channel u_ch_r (
    .clk        (clk),
    .rst        (rst),
    .shadow_we  (wr_en && (off == OFF_DUTY_R)),
    .shadow_din (din),
    .load       (boundary),
    .enable     (ctrl_en.r),
    .cnt        (cnt),
    .shadow_q   (shadow_r),
    .led_n      (led_R)
  );

  pwm_channel u_ch_g (
    .clk        (clk),
    .rst        (rst),
    .shadow_we  (wr_en && (off == OFF_DUTY_G)),
    .shadow_din (din),
    .load       (boundary),
    .enable     (ctrl_en.g),
    .cnt        (cnt),
    .shadow_q   (shadow_g),
    .led_n      (led_G)
  );

  pwm_channel u_ch_b (
    .clk        (clk),
    .rst        (rst),
    .shadow_we  (wr_en && (off == OFF_DUTY_B)),
    .shadow_din (din),
    .load       (boundary),
    .enable     (ctrl_en.b),
    .cnt        (cnt),
    .shadow_q   (shadow_b),
    .led_n      (led_B)
  );

endmodule

// File: tb/tb_rgb_pwm_periph.sv
// Self-checking bench for rgb_pwm_periph: a behavioural model pushes the
// expected pins and read data every clock, a monitor pops and compares.
module tb_rgb_pwm_periph;

  localparam int BASE = 128;

  typedef struct {
    logic [2:0] led;
    logic [7:0] dout;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  logic       led_R;
  logic       led_G;
  logic       led_B;

  int   testsRun;
  int   testsFailed;
  exp_t expQ[$];

  // Reference model state
  int   mEn;
  int   mShadow[3];
  int   mActive[3];
  int   mPresc;
  int   mPc;
  int   mCnt;
  int   mWrap;

  rgb_pwm_periph dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .read    (read),
    .address (address),
    .din     (din),
    .dout    (dout),
    .led_R   (led_R),
    .led_G   (led_G),
    .led_B   (led_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: channel ordering R=0,G=1,B=2, CTRL enable R is bit 2
  always @(posedge clk) begin
    exp_t e;
    bit   mapped, doRead, tickNow, bnd;
    int   offs;
    e.dout = 8'h00;
    if (!rst) begin
      mEn = 0; mPresc = 0; mPc = 0; mCnt = 0; mWrap = 0;
      for (int i = 0; i < 3; i++) begin
        mShadow[i] = 0;
        mActive[i] = 0;
      end
      e.led = 3'b111;
    end else begin
      e.led[2] = !(mEn[2] && mCnt < mActive[0]);
      e.led[1] = !(mEn[1] && mCnt < mActive[1]);
      e.led[0] = !(mEn[0] && mCnt < mActive[2]);
      mapped = (int'(address) >= BASE) && (int'(address) <= BASE + 4);
      offs   = int'(address) - BASE;
      doRead = read && !write;
      if (doRead && mapped) begin
        case (offs)
          0:       e.dout = 8'((mWrap << 7) | mEn);
          4:       e.dout = 8'(mPresc);
          default: e.dout = 8'(mShadow[offs-1]);
        endcase
      end
      tickNow = (mPc == mPresc);
      bnd     = tickNow && (mCnt == 255);
      if (bnd)
        for (int i = 0; i < 3; i++) mActive[i] = mShadow[i];
      if (write && mapped && offs == 4) mPc = 0;
      else if (tickNow)                 mPc = 0;
      else                              mPc = mPc + 1;
      if (tickNow) mCnt = (mCnt + 1) % 256;
      if (bnd)                              mWrap = 1;
      else if (doRead && mapped && offs == 0) mWrap = 0;
      if (write && mapped) begin
        case (offs)
          0:       mEn = int'(din[2:0]);
          4:       mPresc = int'(din);
          default: mShadow[offs-1] = int'(din);
        endcase
      end
    end
    expQ.push_back(e);
  end

  // Monitor: one expectation per clock; an asserted async reset forces pins off
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (!rst) begin
        e.led  = 3'b111;
        e.dout = 8'h00;
      end
      checkOutput("leds", int'({led_R, led_G, led_B}), int'(e.led));
      checkOutput("dout", int'(dout), int'(e.dout));
    end
  end

  // Drive one bus cycle; callers sit just after a rising edge
  task automatic applyStimulus(input bit w, input bit r, input int addr, input int data);
    write   = w;
    read    = r;
    address = 8'(addr);
    din     = 8'(data);
    @(posedge clk);
    #2;
    write   = 1'b0;
    read    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Step until the coming rising edge is a period boundary
  task automatic waitBoundary();
    int guard;
    guard = 0;
    while (!(mCnt == 255 && mPc == mPresc) && guard < 5000) begin
      idle(1);
      guard++;
    end
    checkOutput("boundary_wait_timeout", int'(guard >= 5000), 0);
  endtask

  // Count low cycles on one LED over n clocks
  task automatic measureLow(input int ch, input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      case (ch)
        0:       lows += int'(!led_R);
        1:       lows += int'(!led_G);
        default: lows += int'(!led_B);
      endcase
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int lows;
    int sel;
    int addr;
    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    address = 8'h00;
    din     = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;

    for (int a = BASE; a <= BASE + 5; a++) applyStimulus(0, 1, a, 0);

    // Basic duty on red, no prescale
    applyStimulus(1, 0, BASE + 1, 64);
    applyStimulus(1, 0, BASE + 0, 3'b100);
    idle(300);
    measureLow(0, 512, lows);
    checkOutput("red_low_64", lows, 128);
    measureLow(1, 256, lows);
    checkOutput("green_dark", lows, 0);

    // Double buffering on green
    applyStimulus(1, 0, BASE + 0, 3'b110);
    applyStimulus(1, 0, BASE + 2, 200);
    idle(300);
    measureLow(1, 256, lows);
    checkOutput("green_low_200", lows, 200);
    waitBoundary();
    applyStimulus(1, 0, BASE + 2, 50);
    measureLow(1, 256, lows);
    checkOutput("green_boundary_write_delayed", lows, 200);
    idle(10);
    measureLow(1, 256, lows);
    checkOutput("green_low_50", lows, 50);

    // WRAP polling, including a read on the boundary cycle
    applyStimulus(0, 1, BASE, 0);
    waitBoundary();
    applyStimulus(0, 1, BASE, 0);
    applyStimulus(0, 1, BASE, 0);
    applyStimulus(0, 1, BASE, 0);

    // Prescaler 3 on blue
    applyStimulus(1, 0, BASE + 4, 3);
    applyStimulus(1, 0, BASE + 3, 128);
    applyStimulus(1, 0, BASE + 0, 3'b001);
    idle(1100);
    measureLow(2, 2048, lows);
    checkOutput("blue_low_presc3", lows, 1024);
    idle(101);
    applyStimulus(1, 0, BASE + 4, 3);
    idle(50);

    // Edge duties on red with no prescale
    applyStimulus(1, 0, BASE + 4, 0);
    applyStimulus(1, 0, BASE + 1, 0);
    applyStimulus(1, 0, BASE + 0, 3'b100);
    idle(600);
    measureLow(0, 256, lows);
    checkOutput("red_duty0", lows, 0);
    applyStimulus(1, 0, BASE + 1, 255);
    idle(300);
    measureLow(0, 256, lows);
    checkOutput("red_duty255", lows, 255);

    // Bus corner cases
    applyStimulus(0, 1, BASE + 5, 0);
    applyStimulus(1, 1, BASE + 1, 8'h55);
    applyStimulus(0, 1, BASE + 1, 0);

    // Randomised traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
      end
      sel  = int'($urandom_range(0, 9));
      addr = int'($urandom_range(BASE - 2, BASE + 6));
      if (sel < 2)
        applyStimulus(1, 0, addr, (addr == BASE + 4) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255)));
      else if (sel < 4)
        applyStimulus(0, 1, addr, 0);
      else if (sel == 4)
        applyStimulus(1, 1, addr, (addr == BASE + 4) ? 1 : int'($urandom_range(0, 255)));
      else
        idle(1);
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_periph.md
# rgb_pwm_periph

Memory-mapped RGB LED PWM controller on the NECPU 8-bit CPU bus; it sits between the CPU's write/read/address/data bus and the board's active-low RGB LED pins. It provides per-channel 8-bit duty cycles with a programmable prescaler. Duty values are double-buffered so updates take effect only at a PWM period boundary. A sticky period-wrap flag lets software pace colour fades by polling.

## Interface
- BASE_ADDR, 8'd128: byte address of register 0; registers occupy BASE_ADDR..BASE_ADDR+4.
- PRESC_W, 8: prescaler register/counter width.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- write  in  1  CPU write strobe, one cycle per access.
- read  in  1  CPU read strobe, one cycle per access.
- address  in  8  CPU byte address.
- din  in  8  CPU write data.
- dout  out  8  read data to CPU, registered.
- led_R, led_G, led_B  out  1 each  LED drives, active-low; 1 = off.

## Operation
- Register map, offset from BASE_ADDR:
  - +0 CTRL: bits [2:0] = enable R,G,B (RW); bit 7 = WRAP (RO, sticky); bits [6:3] read 0.
  - +1/+2/+3 DUTY_R/G/B: shadow duty (RW).
  - +4 PRESC: divisor; one PWM tick every PRESC+1 clocks.
- Prescaler:
  - Counter counts 0..PRESC; `tick` pulses when it equals PRESC, then it returns to 0.
  - Any write to PRESC clears the prescaler counter.
- PWM counter:
  - 8-bit `cnt`, advances on `tick`; 255 → 0 wraps with no saturation.
  - Period = 256 × (PRESC+1) clocks.
- Period boundary: defined as `tick` with cnt==255. At a boundary:
  - All three shadow duties copy to active duties.
  - WRAP sets.
- Channel on condition: enable bit set AND cnt < active duty (unsigned 8-bit compare).
  - Duty 0 = never on; duty 255 = on 255/256 of the period.
  - led_x = ~on, registered.
- Enable changes act immediately, with no wait for the boundary.
- Reads:
  - Any read of CTRL clears WRAP.
  - If a boundary coincides with a CTRL read, set wins: WRAP stays 1, and dout returns the pre-event value.
- Unmapped addresses: writes are ignored; reads return 8'h00.
- Simultaneous write and read strobes: the write is performed; the read is ignored and dout = 8'h00.
- Shadow readback: DUTY reads return the shadow value, not the active one.

## Timing
- Reset (rst=0, async) values:
  - CTRL, shadow and active duties, PRESC, prescaler counter, cnt, WRAP = 0.
  - dout = 8'h00.
  - led_R/G/B = 1 (off).
- Register writes are visible to reads on the following cycle.
- Read latency is 1: dout is valid the cycle after `read`, and is 8'h00 in any cycle not following a read.
- LED latency: led_x reflects the cnt/enable/active-duty state of the previous cycle (one flop).
- Duty latency: a DUTY write lands at the next period boundary.
  - A write in the same cycle as a boundary is not captured; it waits a full period.
- Reset deasserted mid-period restarts the PWM from cnt=0 with all LEDs off.

## Structure
- Shared package `necpu_pkg` holds:
  - register offset localparams (OFF_CTRL=0, OFF_DUTY_R=1, OFF_DUTY_G=2, OFF_DUTY_B=3, OFF_PRESC=4);
  - WRAP bit index (7);
  - LED_OFF constant (1'b1).
- Sub-module `pwm_channel`, instantiated ×3:
  - inputs: clk, rst, shadow-write strobe + data, load (boundary), enable, cnt;
  - state: shadow/active duty registers, compare, active-low output flop;
  - output: shadow readback.
- The top module owns address decode, CTRL/PRESC registers, prescaler, cnt, WRAP and the dout mux.

## Test plan
- Reset: hold rst=0 mid-operation, then release → leds=1, all reads return 8'h00, WRAP=0.
- Basic duty, no prescale:
  - PRESC=0, DUTY_R=64, CTRL=3'b100, run 2 periods;
  - led_R low for exactly 64 of every 256 clocks starting at the first boundary; led_G and led_B stay 1.
- Double-buffer:
  - Write DUTY_G=200 at cnt=10 → no change until the next cnt wrap, then 200/256 low;
  - A write on the boundary cycle is delayed one extra period.
- Prescaler:
  - PRESC=3, DUTY_B=128, enable B → period 1024 clocks, led_B low 512 clocks;
  - Rewriting PRESC mid-period restarts the prescale count.
- WRAP flag:
  - Poll CTRL across a boundary → bit7=1 on the first read after the boundary, 0 on the next read;
  - A CTRL read on the exact boundary cycle returns 0 and WRAP remains set.
- Edge values and bus corner cases:
  - DUTY=0 → led stays 1; DUTY=255 → led high exactly 1 clock per period (PRESC=0);
  - read of BASE_ADDR+5 → 8'h00;
  - write+read in the same cycle to DUTY_R=0x55 → later read returns 0x55, same-cycle dout=8'h00.
